token_matcher: RTL and testbench
================================

TOKEN_MATCHER -- requirements
Module: token_matcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: vocab depth DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter WORD_LENGTH, default 3: characters per entry.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: bits per character.
REQ-004 SHALL have parameter LANES, default 2: entries compared per cycle; must be a power of two no greater than DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_word (input, WORD_LENGTH*DATA_WIDTH): append one vocab entry.
REQ-008 SHALL have ports q_valid (input, 1), q_ready (output, 1), q_word (input, WORD_LENGTH*DATA_WIDTH): search query.
REQ-009 SHALL have ports q_len (input, $clog2(WORD_LENGTH+1)) and q_prefix (input, 1): character count to compare, and prefix-mode select.
REQ-010 SHALL have ports r_valid (input-side output, 1) and r_ready (input, 1): result handshake.
REQ-011 SHALL have ports r_found (output, 1) and r_index (output, ADDR_WIDTH): match flag and matching entry index.
REQ-012 SHALL have ports vocab_count (output, ADDR_WIDTH+1) and vocab_overflow (output, 1): occupancy and sticky overflow flag.
REQ-013 SHALL have port nullptr_vocab (output, 1): result was produced against an empty vocab.

Function
REQ-014 SHALL store each accepted write at index vocab_count, then increment vocab_count; write accepted when wr_valid && wr_ready.
REQ-015 SHALL drive wr_ready = 1 only in IDLE with vocab_count < DEPTH.
REQ-016 SHALL set vocab_overflow and drop the data on wr_valid in IDLE with vocab_count == DEPTH; the flag stays set until reset.
REQ-017 SHALL drive q_ready = 1 only in IDLE with wr_valid == 0, so a write wins a same-cycle collision.
REQ-018 SHALL run FSM states IDLE, SCAN, RESP.
REQ-019 In IDLE, on query accept, SHALL latch q_word, q_len and q_prefix, clear the scan base to 0, and go to SCAN; if vocab_count == 0, SHALL go directly to RESP with r_found = 0 and nullptr_vocab = 1.
REQ-020 In SCAN, each cycle SHALL compare entries base..base+LANES-1, ignoring indices >= vocab_count.
REQ-021 Exact mode (q_prefix = 0) SHALL compare all WORD_LENGTH characters and ignore q_len.
REQ-022 Prefix mode SHALL compare the most-significant q_len characters; q_len = 0 matches every entry; q_len > WORD_LENGTH is treated as WORD_LENGTH.
REQ-023 SHALL report the lowest matching index when several lanes match, and go to RESP the next cycle.
REQ-024 With no hit, SHALL add LANES to base; when base + LANES >= vocab_count, SHALL go to RESP with r_found = 0.
REQ-025 Worst-case latency from query accept to r_valid SHALL be ceil(vocab_count/LANES)+1 cycles; a hit in the first lane group gives 2 cycles.
REQ-026 In RESP, SHALL assert r_valid and hold r_found, r_index and nullptr_vocab stable until r_ready; on r_valid && r_ready, SHALL return to IDLE.
REQ-027 r_index SHALL be 0 whenever r_found = 0.

Reset
REQ-028 rst SHALL force IDLE, vocab_count = 0, vocab_overflow = 0, r_valid = 0, r_found = 0, r_index = 0, nullptr_vocab = 0, from any state including mid-SCAN and RESP, and SHALL discard the pending query.
REQ-029 Vocab storage contents need not be cleared by reset; entries at or above vocab_count are never compared.

Structure
REQ-030 A shared package tm_pkg SHALL hold the FSM state enum and a function computing the compare mask from q_len.
REQ-031 One sub-module, tm_lane_cmp, SHALL compare a single entry against the query under the mask; the top SHALL instantiate LANES copies.

Verification (ADDR_WIDTH=4, WORD_LENGTH=3, DATA_WIDTH=8, LANES=2)
REQ-032 Empty-vocab query: query "Hel" with vocab_count 0 -> r_valid 1 cycle later, r_found 0, nullptr_vocab 1.
REQ-033 Exact hit: load "abc","Hel","xyz","Hel", then query "Hel" exact -> r_found 1, r_index 1, r_valid 2 cycles after accept.
REQ-034 Prefix and miss: same vocab, prefix q_len 1, "x??" -> r_index 2; exact "Hex" -> r_found 0 after 3 cycles.
REQ-035 Overflow: 17 writes -> vocab_count 16, wr_ready 0 after the 16th write, vocab_overflow 1 on the 17th, entry 15 unchanged.
REQ-036 Backpressure and reset: hold r_ready 0 for 5 cycles -> outputs stable, q_ready 0; assert rst mid-SCAN -> all outputs reach reset values next cycle.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and helpers for the token matcher: FSM state encoding and the per-character compare enable.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tm_pkg;

   // Controller states: accept traffic, walk the vocab in lane groups, hold the result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } tm_state_t;

   // Compare-mask bit for one character position. char_idx counts from the least-significant
   // character (0) up to word_length-1 (the leading character of the word). Exact mode enables
   // every character; prefix mode enables only the leading min(len, word_length) characters,
   // so len = 0 enables nothing and every live entry matches.
   function automatic logic tm_char_en(
      input int unsigned word_length,
      input int unsigned len,
      input logic        prefix,
      input int unsigned char_idx
   );
      int unsigned eff_len;
      if (!prefix) begin
         return 1'b1;
      end
      eff_len = (len > word_length) ? word_length : len;
      return ((char_idx + eff_len) >= word_length);
   endfunction

endpackage

// File: rtl/tm_lane_cmp.sv
// One compare lane: does a single vocab entry match the query on every enabled character?
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with entry_live.
module tm_lane_cmp #(
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0] entry_word,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0] query_word,
   input  logic [WORD_LENGTH-1:0]            char_mask,
   input  logic                              entry_live,
   output logic                              hit
);

   logic [WORD_LENGTH-1:0] char_ok;

   // A masked-off character always counts as matching
   for (genvar c = 0; c < WORD_LENGTH; c++) begin : g_char
      assign char_ok[c] = !char_mask[c] ||
         (entry_word[c*DATA_WIDTH +: DATA_WIDTH] == query_word[c*DATA_WIDTH +: DATA_WIDTH]);
   end

   // Entries at or beyond the current occupancy never hit, whatever stale data they hold
   assign hit = entry_live && (&char_ok);

endmodule

// File: rtl/token_matcher.sv
// Append-only vocab with a LANES-wide linear search returning the lowest matching index.
// Latency: query accept to r_valid is 1 cycle on an empty vocab, else one cycle per lane group scanned plus 1.
// Backpressure: wr/q accepted only in IDLE (a write beats a same-cycle query); result held in RESP until r_ready.
module token_matcher
   import tm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int LANES       = 2   // power of two, no larger than the vocab depth
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0]    wr_word,
   input  logic                                 q_valid,
   output logic                                 q_ready,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0]    q_word,
   input  logic [$clog2(WORD_LENGTH+1)-1:0]     q_len,
   input  logic                                 q_prefix,
   output logic                                 r_valid,
   input  logic                                 r_ready,
   output logic                                 r_found,
   output logic [ADDR_WIDTH-1:0]                r_index,
   output logic [ADDR_WIDTH:0]                  vocab_count,
   output logic                                 vocab_overflow,
   output logic                                 nullptr_vocab
);

   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;
   localparam int LEN_W  = $clog2(WORD_LENGTH + 1);
   localparam int IDX_W  = ADDR_WIDTH + 1;

   // Occupancy value meaning "vocab full", and the per-cycle base stride
   localparam logic [IDX_W-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [IDX_W-1:0] LANES_C  = IDX_W'(LANES);

   // Query as captured at accept time; held for the whole scan
   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [LEN_W-1:0]  len;
      logic              prefix;
   } query_t;

   tm_state_t          state;
   tm_state_t          state_nxt;
   query_t             query_q;
   logic [IDX_W-1:0]   base;
   logic [WORD_W-1:0]  vocab_mem [DEPTH];

   logic [WORD_LENGTH-1:0] char_mask;
   logic [IDX_W-1:0]       lane_idx [LANES];
   logic [LANES-1:0]       lane_hit;
   logic                   hit_any;
   logic [ADDR_WIDTH-1:0]  hit_idx;
   logic                   scan_last;
   logic                   wr_accept;
   logic                   wr_drop;
   logic                   q_accept;
   logic                   vocab_empty;

   assign vocab_empty = (vocab_count == '0);
   assign wr_accept   = wr_valid && wr_ready;
   assign wr_drop     = wr_valid && (state == IDLE) && (vocab_count == FULL_CNT);
   assign q_accept    = q_valid && q_ready;

   // The current group is the last one when it reaches the end of the occupied region
   assign scan_last = ((base + LANES_C) >= vocab_count);

   // Compare mask derived once from the latched query; shared by all lanes
   for (genvar c = 0; c < WORD_LENGTH; c++) begin : g_mask
      assign char_mask[c] = tm_char_en(WORD_LENGTH, 32'(query_q.len), query_q.prefix, c);
   end

   // Lane l looks at entry base+l; the base is a multiple of LANES so the group never straddles DEPTH
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = base + IDX_W'(l);

      tm_lane_cmp #(
         .WORD_LENGTH (WORD_LENGTH),
         .DATA_WIDTH  (DATA_WIDTH)
      ) u_lane_cmp (
         .entry_word (vocab_mem[lane_idx[l][ADDR_WIDTH-1:0]]),
         .query_word (query_q.word),
         .char_mask  (char_mask),
         .entry_live (lane_idx[l] < vocab_count),
         .hit        (lane_hit[l])
      );
   end

   // Priority pick: walk lanes from highest to lowest so the lowest hitting lane wins
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (lane_hit[l]) begin
            hit_any = 1'b1;
            hit_idx = lane_idx[l][ADDR_WIDTH-1:0];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      q_ready   = 1'b0;
      r_valid   = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = (vocab_count != FULL_CNT);
            q_ready  = !wr_valid;
            if (q_valid && !wr_valid) begin
               state_nxt = vocab_empty ? RESP : SCAN;
            end
         end
         SCAN: begin
            if (hit_any || scan_last) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            r_valid = 1'b1;
            if (r_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy, overflow, query capture, scan pointer and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vocab_count    <= '0;
         vocab_overflow <= 1'b0;
         query_q        <= '0;
         base           <= '0;
         r_found        <= 1'b0;
         r_index        <= '0;
         nullptr_vocab  <= 1'b0;
      end else begin
         if (wr_accept) begin
            vocab_count <= vocab_count + 1'b1;
         end
         if (wr_drop) begin
            vocab_overflow <= 1'b1;
         end
         if (q_accept) begin
            query_q.word   <= q_word;
            query_q.len    <= q_len;
            query_q.prefix <= q_prefix;
            base           <= '0;
            r_found        <= 1'b0;
            r_index        <= '0;
            nullptr_vocab  <= vocab_empty;
         end
         if (state == SCAN) begin
            if (hit_any) begin
               r_found <= 1'b1;
               r_index <= hit_idx;
            end else if (!scan_last) begin
               base <= base + LANES_C;
            end
         end
      end
   end

   // Vocab storage: not reset, anything at or above vocab_count is ignored by the lanes
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         vocab_mem[vocab_count[ADDR_WIDTH-1:0]] <= wr_word;
      end
   end

endmodule

// File: tb/tb_token_matcher.sv
// Randomized and directed bench for token_matcher with a queue-based scoreboard.
// Latency: checks query-accept to r_valid cycle counts against the reference model.
// Backpressure: r_ready driven randomly or forced low/high per phase.
module tb_token_matcher;

   localparam int AW    = 4;
   localparam int WL    = 3;
   localparam int DW    = 8;
   localparam int LN    = 2;
   localparam int DEPTH = 16;
   localparam int P     = 10;
   localparam int HALF  = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_valid;
   logic            wr_ready;
   logic [WL*DW-1:0] wr_word;
   logic            q_valid;
   logic            q_ready;
   logic [WL*DW-1:0] q_word;
   logic [1:0]      q_len;
   logic            q_prefix;
   logic            r_valid;
   logic            r_ready;
   logic            r_found;
   logic [AW-1:0]   r_index;
   logic [AW:0]     vocab_count;
   logic            vocab_overflow;
   logic            nullptr_vocab;

   token_matcher #(
      .ADDR_WIDTH  (AW),
      .WORD_LENGTH (WL),
      .DATA_WIDTH  (DW),
      .LANES       (LN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_word        (wr_word),
      .q_valid        (q_valid),
      .q_ready        (q_ready),
      .q_word         (q_word),
      .q_len          (q_len),
      .q_prefix       (q_prefix),
      .r_valid        (r_valid),
      .r_ready        (r_ready),
      .r_found        (r_found),
      .r_index        (r_index),
      .vocab_count    (vocab_count),
      .vocab_overflow (vocab_overflow),
      .nullptr_vocab  (nullptr_vocab)
   );

   always #HALF clk = ~clk;

   typedef struct {
      logic   found;
      int     idx;
      logic   nullp;
      int     lat;
      longint t_acc;
   } exp_t;

   exp_t        expq[$];
   logic [WL*DW-1:0] m_mem [DEPTH];
   int          m_count;
   logic        m_ovf;
   int          n_checks = 0;
   int          n_err    = 0;
   int          resp_cnt = 0;
   int          rdy_mode = 2;   // 0 random, 1 never ready, 2 always ready

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference search: first occupied entry whose leading characters equal the query's
   function automatic exp_t model_query(input logic [WL*DW-1:0] w, input int len, input bit pre);
      exp_t e;
      int   eff;
      bit   match;
      eff     = pre ? ((len > WL) ? WL : len) : WL;
      e.found = 1'b0;
      e.idx   = 0;
      e.nullp = (m_count == 0);
      e.t_acc = 0;
      for (int i = 0; i < m_count; i++) begin
         match = 1'b1;
         for (int c = 0; c < eff; c++) begin
            if (m_mem[i][(WL-1-c)*DW +: DW] != w[(WL-1-c)*DW +: DW]) match = 1'b0;
         end
         if (match && !e.found) begin
            e.found = 1'b1;
            e.idx   = i;
         end
      end
      if (m_count == 0)  e.lat = 1;
      else if (e.found)  e.lat = e.idx / LN + 2;
      else               e.lat = (m_count + LN - 1) / LN + 1;
      return e;
   endfunction

   // Result-side driver
   initial begin
      r_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       r_ready = 1'($urandom_range(0, 1));
            1:       r_ready = 1'b0;
            default: r_ready = 1'b1;
         endcase
      end
   end

   // Monitor: latency on first r_valid, stability while stalled, full compare on handshake
   logic   in_resp = 1'b0;
   logic   held    = 1'b0;
   logic   h_found;
   logic   h_nullp;
   logic [AW-1:0] h_index;
   int     meas_lat = 0;
   longint now_t;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_resp = 1'b0;
            held    = 1'b0;
         end else if (r_valid) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_result: got r_valid=1 expected no pending query at t=%0t", $time);
            end else begin
               now_t = $time;
               if (!in_resp) begin
                  in_resp  = 1'b1;
                  meas_lat = int'((now_t - expq[0].t_acc - HALF) / P) + 1;
               end
               if (held) begin
                  chk("hold_found", r_found, h_found);
                  chk("hold_index", r_index, h_index);
                  chk("hold_nullptr", nullptr_vocab, h_nullp);
               end
               if (r_ready) begin
                  chk("r_found", r_found, expq[0].found);
                  chk("r_index", r_index, expq[0].idx);
                  chk("nullptr_vocab", nullptr_vocab, expq[0].nullp);
                  chk("latency", meas_lat, expq[0].lat);
                  void'(expq.pop_front());
                  in_resp = 1'b0;
                  held    = 1'b0;
                  resp_cnt++;
               end else begin
                  held    = 1'b1;
                  h_found = r_found;
                  h_index = r_index;
                  h_nullp = nullptr_vocab;
               end
            end
         end
      end
   end

   task automatic check_reset_outputs();
      @(negedge clk);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_found", r_found, 0);
      chk("rst_r_index", r_index, 0);
      chk("rst_nullptr", nullptr_vocab, 0);
      chk("rst_count", vocab_count, 0);
      chk("rst_overflow", vocab_overflow, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_q_ready", q_ready, 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      expq.delete();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_count = 0;
      m_ovf   = 1'b0;
      check_reset_outputs();
   endtask

   task automatic wait_resp(input int start);
      int b;
      b = 0;
      while (resp_cnt == start && b < 300) begin
         @(negedge clk);
         b++;
      end
      n_checks++;
      if (resp_cnt == start) begin
         n_err++;
         $display("FAIL resp_timeout: got no result after %0d cycles expected one", b);
         expq.delete();
      end
   endtask

   task automatic write_word(input logic [WL*DW-1:0] w);
      bit exp_rdy;
      @(posedge clk);
      #1;
      exp_rdy  = (m_count < DEPTH);
      wr_valid = 1'b1;
      wr_word  = w;
      @(negedge clk);
      chk("wr_ready", wr_ready, exp_rdy);
      chk("q_ready_during_write", q_ready, 0);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      if (exp_rdy) begin
         m_mem[m_count] = w;
         m_count++;
      end else begin
         m_ovf = 1'b1;
      end
      @(negedge clk);
      chk("vocab_count", vocab_count, m_count);
      chk("vocab_overflow", vocab_overflow, m_ovf);
   endtask

   task automatic query(input logic [WL*DW-1:0] w, input int len, input bit pre, input bit wait_it);
      exp_t e;
      int   start;
      @(posedge clk);
      #1;
      e        = model_query(w, len, pre);
      start    = resp_cnt;
      q_valid  = 1'b1;
      q_word   = w;
      q_len    = 2'(len);
      q_prefix = pre;
      @(negedge clk);
      chk("q_ready", q_ready, 1);
      e.t_acc = $time + HALF;
      expq.push_back(e);
      @(posedge clk);
      #1;
      q_valid = 1'b0;
      if (wait_it) wait_resp(start);
   endtask

   function automatic logic [WL*DW-1:0] rand_word();
      logic [WL*DW-1:0] w;
      for (int c = 0; c < WL; c++) w[c*DW +: DW] = 8'(8'h61 + $urandom_range(0, 2));
      return w;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      int b;
      logic            c_found;
      logic [AW-1:0]   c_index;
      logic [WL*DW-1:0] w;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_word  = '0;
      q_valid  = 1'b0;
      q_word   = '0;
      q_len    = '0;
      q_prefix = 1'b0;
      m_count  = 0;
      m_ovf    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs();

      // Empty vocab, then the small worked vocab
      query("Hel", 3, 1'b0, 1'b1);
      write_word("abc");
      write_word("Hel");
      write_word("xyz");
      write_word("Hel");
      query("Hel", 0, 1'b0, 1'b1);
      query("x??", 1, 1'b1, 1'b1);
      query("Hex", 0, 1'b0, 1'b1);
      query("Hez", 2, 1'b1, 1'b1);
      query("q??", 0, 1'b1, 1'b1);

      // Result held under backpressure
      rdy_mode = 1;
      start = resp_cnt;
      query("xyz", 0, 1'b0, 1'b0);
      b = 0;
      while (!r_valid && b < 50) begin
         @(negedge clk);
         b++;
      end
      c_found = r_found;
      c_index = r_index;
      chk("stall_found", c_found, 1);
      chk("stall_index", c_index, 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_r_valid", r_valid, 1);
         chk("stall_q_ready", q_ready, 0);
         chk("stall_index_stable", r_index, c_index);
      end
      rdy_mode = 2;
      wait_resp(start);

      // Fill to capacity plus one dropped write
      do_reset();
      for (int i = 0; i < 17; i++) begin
         w = {8'(8'h41 + i), 8'h71, 8'h72};
         write_word(w);
      end
      query({8'h50, 8'h71, 8'h72}, 0, 1'b0, 1'b1);
      query({8'h51, 8'h71, 8'h72}, 0, 1'b0, 1'b1);

      // Reset while scanning a full vocab
      query("zzz", 0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      expq.delete();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_count = 0;
      m_ovf   = 1'b0;
      check_reset_outputs();

      // Randomized traffic
      rdy_mode = 0;
      for (int it = 0; it < 150; it++) begin
         if (m_count == DEPTH && $urandom_range(0, 15) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 2) == 0 && (m_count < DEPTH || $urandom_range(0, 7) == 0)) begin
            write_word(rand_word());
         end else begin
            if (m_count > 0 && $urandom_range(0, 1) == 1) w = m_mem[$urandom_range(0, m_count - 1)];
            else w = rand_word();
            query(w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
